alu8_pipe_stage: RTL



---
 rtl/alu8_pkg.sv | 35 +++
 rtl/alu8_logic_core.sv | 34 +++
 rtl/alu8_pipe_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/alu8_pkg.sv
// Shared opcode, width and flag definitions for the 8-bit logic ALU stage.
package alu8_pkg;

  localparam int DW        = 8;
  localparam int NUM_FLAGS = 2;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_PAR  = 1;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_PASS_B = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          acc;
  } cmd_t;

  function automatic logic [NUM_FLAGS-1:0] calc_flags(input logic [DW-1:0] d);
    logic [NUM_FLAGS-1:0] f;
    f            = '0;
    f[FLAG_ZERO] = (d == '0);
    f[FLAG_PAR]  = ^d;
    return f;
  endfunction

endpackage

// File: rtl/alu8_logic_core.sv
// Combinational 8-bit AND/OR/XOR gate array feeding the 8-way result mux.
module alu8_logic_core
  import alu8_pkg::*;
(
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result
);

  logic [DW-1:0] and_v, or_v, xor_v;

  for (genvar i = 0; i < DW; i++) begin : g_bit
    assign and_v[i] = a[i] & b[i];
    assign or_v[i]  = a[i] | b[i];
    assign xor_v[i] = a[i] ^ b[i];
  end

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      OP_AND:    result = and_v;
      OP_OR:     result = or_v;
      OP_XOR:    result = xor_v;
      OP_NAND:   result = ~and_v;
      OP_NOR:    result = ~or_v;
      OP_XNOR:   result = ~xor_v;
      OP_PASS_A: result = a;
      OP_PASS_B: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu8_pipe_stage.sv
// Two-stage valid/ready issue/result stage around alu8_logic_core.
// Optional accumulator operand enabled by defining ALU8_ACC_EN.
module alu8_pipe_stage
  import alu8_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_acc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_zero,
  output logic          out_par
);

  cmd_t                 s1;
  logic                 s1_valid;
  logic                 s2_valid;
  logic [DW-1:0]        s2_data;
  logic [NUM_FLAGS-1:0] s2_flags;
  logic                 s1_adv, take;
  logic [DW-1:0]        op_a, result;

  assign s1_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign take     = in_valid && in_ready;

`ifdef ALU8_ACC_EN
  logic [DW-1:0] acc;

  assign op_a = s1.acc ? acc : s1.a;

  // Tracks the most recent S1 result; draining S2 leaves it alone.
  always_ff @(posedge clk) begin
    if (rst)         acc <= '0;
    else if (s1_adv) acc <= result;
  end
`else
  logic unused_acc;

  assign op_a       = s1.a;
  assign unused_acc = s1.acc;
`endif

  alu8_logic_core u_core (
    .op     (s1.op),
    .a      (op_a),
    .b      (s1.b),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s1_valid <= 1'b0;
    end else if (take) begin
      s1       <= '{op: in_op, a: in_a, b: in_b, acc: in_acc};
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Flags are registered alongside the data so they read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_flags <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= result;
      s2_flags <= calc_flags(result);
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zero  = s2_flags[FLAG_ZERO];
  assign out_par   = s2_flags[FLAG_PAR];

endmodule
